interp_step_sequencer: RTL and testbench
========================================

Name: interp_step_sequencer

Overview:
Upstream driver for InterpolationModule. It walks the requested output time points tk = t_begin + i*h for i = 0..n_steps-1. For each point it presents tk_port and uk_port, pulses start_sg, and waits for done_sg. It pulses init_sg once per run, and aborts with a sticky error on interpolator overflow, tk arithmetic overflow, or a done_sg timeout.

Parameters:
WORD_SIZE, 16, signed fixed-point word width (7 fractional bits; 1.0 = 0x0080)
ADDRESS_WIDTH, 16, RAM address width for uk_port
CNT_WIDTH, 10, width of step count/index
TIMEOUT, 1023, max cycles in WAIT before error

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
go  in  1  start a run (sampled only in IDLE, DONE or ERR)
t_begin  in  WORD_SIZE  first tk, captured on accepted go
h_step  in  WORD_SIZE  tk increment, signed, captured on accepted go
n_steps  in  CNT_WIDTH  number of points, captured on accepted go
uk_base  in  ADDRESS_WIDTH  uk address for i=0, captured on accepted go
u_stride  in  ADDRESS_WIDTH  uk address increment per point
interp_done  in  1  done_sg from interpolator
interp_overflow  in  1  overflow from interpolator
init_sg  out  1  one-cycle pulse to interpolator at run start
start_sg  out  1  one-cycle pulse per point
tk_port  out  WORD_SIZE  current tk, stable from ISSUE until ADVANCE
uk_port  out  ADDRESS_WIDTH  current uk address, same stability as tk_port
step_idx  out  CNT_WIDTH  index of current point
busy  out  1  high in INIT/ISSUE/WAIT/ADVANCE
seq_done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag
err_code  out  2  00 none, 01 interp overflow, 10 tk overflow, 11 timeout

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All outputs 0; internal tk/uk/idx/timer/captured registers 0.
- States: IDLE, INIT, ISSUE, WAIT, ADVANCE, DONE, ERR.
- IDLE/DONE/ERR, go=1: capture inputs; tk<=t_begin, uk<=uk_base, idx<=0; clear err/err_code.
  - If n_steps=0: next state DONE, seq_done pulses the following cycle, and no init_sg is issued.
  - Otherwise: next state INIT.
- INIT: init_sg=1 for this cycle only -> ISSUE.
- ISSUE: start_sg=1 for this cycle only; timer<=0 -> WAIT.
- WAIT: timer increments each cycle.
  - interp_overflow=1 -> ERR, code 01. This has priority over a simultaneous interp_done.
  - Else interp_done=1 -> ADVANCE.
  - Else timer==TIMEOUT -> ERR, code 11.
- ADVANCE:
  - If idx==n_steps-1 -> DONE.
  - Else tk<=tk+h_step (signed add), uk<=uk+u_stride (modulo 2^ADDRESS_WIDTH wrap, no error), idx<=idx+1 -> ISSUE.
  - Signed overflow of tk+h_step (operands share a sign, result sign differs) -> ERR, code 10; tk is not updated.
- DONE: seq_done=1 for the single cycle after entry, then held state; busy=0.
- ERR: err=1 and err_code held until an accepted go or reset. start_sg/init_sg never asserted in ERR.
- go in busy states is ignored. Captured inputs are not re-sampled mid-run.
- Latency:
  - go to init_sg: 1 cycle.
  - init_sg to first start_sg: 1 cycle.
  - interp_done to next start_sg: 2 cycles (ADVANCE, ISSUE).
- interp_done outside WAIT is ignored.
- Reset asserted mid-run returns the block to IDLE next edge; outputs are cleared in the same edge.

Decomposition:
- Shared package interp_pkg holds:
  - state encoding localparams (IDLE=0 .. ERR=6);
  - err_code constants (ERR_NONE, ERR_IOVF, ERR_TOVF, ERR_TMO);
  - fixed-point constant FRAC_BITS=7 and ONE=0x0080.
- One natural sub-module: sat_add_detect, a signed WORD_SIZE adder that also outputs an overflow flag, used for the tk update.
- The FSM, timer and registers stay in the top module.

Test Plan:
1. t_begin=0x0080, h=0x0040, n=3, uk_base=0x0200, stride=3, interp_done returned 4 cycles after each start_sg -> tk_port 0x0080, 0x00C0, 0x0100; uk_port 0x0200, 0x0203, 0x0206; exactly one init_sg, three start_sg, then one seq_done pulse; err=0.
2. n_steps=0, go -> no init_sg or start_sg, seq_done pulses once, busy stays 0.
3. t_begin=0x7F80, h=0x0100, n=2 -> first point issued at 0x7F80; after its done, ERR with err_code=10; tk_port holds 0x7F80; no second start_sg.
4. interp_overflow=1 and interp_done=1 in the same WAIT cycle of step 1 -> err_code=01, no ADVANCE, no seq_done.
5. interp_done never returned -> err_code=11 exactly TIMEOUT+1 cycles after start_sg. A subsequent go clears err and restarts the run at idx 0.
6. Mid-run behaviour:
   - rst=0 during WAIT of step 1 -> all outputs 0 next edge; state IDLE.
   - go pulsed while busy -> ignored; step sequence unchanged.
   - uk_base=0xFFFE, stride=3 -> second uk_port is 0x0001 (wrap, no error).

Source files
------------

// File: rtl/interp_pkg.sv
// interp_pkg
//   Shared definitions for the interpolation step sequencer: state
//   encoding, error codes and the fixed-point format of tk values.
package interp_pkg;

  // State encoding
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] ADVANCE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = IDLE,
    S_INIT    = INIT,
    S_ISSUE   = ISSUE,
    S_WAIT    = WAIT,
    S_ADVANCE = ADVANCE,
    S_DONE    = DONE,
    S_ERR     = ERR
  } state_t;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE = 2'b00;  // no error
  localparam logic [1:0] ERR_IOVF = 2'b01;  // interpolator overflow
  localparam logic [1:0] ERR_TOVF = 2'b10;  // tk arithmetic overflow
  localparam logic [1:0] ERR_TMO  = 2'b11;  // done_sg timeout

  // Fixed-point format of tk: 7 fractional bits, 1.0 = 0x0080
  localparam int         FRAC_BITS = 7;
  localparam logic [15:0] ONE      = 16'h0080;

endpackage

// File: rtl/sat_add_detect.sv
// sat_add_detect
//   Signed two's-complement adder with an overflow flag. The sum wraps;
//   the caller decides what to do when o_ovf is set.
// Ports:
//   i_a, i_b : signed operands (WIDTH bits)
//   o_sum    : wrapped sum
//   o_ovf    : high when the true sum is not representable in WIDTH bits
module sat_add_detect #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_sum;

  assign w_sum = i_a + i_b;
  assign o_sum = w_sum;

  // Overflow only possible when both operands share a sign and the
  // result sign differs from it.
  assign o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/interp_step_sequencer.sv
// interp_step_sequencer
//   Drives an interpolator through the time points
//   tk = t_begin + i*h_step, i = 0..n_steps-1. Per point it presents
//   tk_port/uk_port, pulses start_sg and waits for done_sg. One init_sg
//   pulse per run. Aborts with a sticky error on interpolator overflow,
//   tk overflow or a done_sg timeout.
// Ports:
//   clk, rst                 : clock (rising edge), synchronous active-low reset
//   go                       : start a run (accepted in IDLE/DONE/ERR only)
//   t_begin, h_step, n_steps : time base, signed increment, point count
//   uk_base, u_stride        : uk address of point 0 and per-point increment
//   interp_done/overflow     : handshake and error from the interpolator
//   init_sg, start_sg        : one-cycle pulses to the interpolator
//   tk_port, uk_port         : current point, stable from ISSUE to ADVANCE
//   step_idx                 : index of the current point
//   busy, seq_done           : run in progress / one-cycle completion pulse
//   err, err_code            : sticky error flag and cause
module interp_step_sequencer #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int CNT_WIDTH     = 10,
  parameter int TIMEOUT       = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [WORD_SIZE-1:0]     t_begin,
  input  logic [WORD_SIZE-1:0]     h_step,
  input  logic [CNT_WIDTH-1:0]     n_steps,
  input  logic [ADDRESS_WIDTH-1:0] uk_base,
  input  logic [ADDRESS_WIDTH-1:0] u_stride,
  input  logic                     interp_done,
  input  logic                     interp_overflow,
  output logic                     init_sg,
  output logic                     start_sg,
  output logic [WORD_SIZE-1:0]     tk_port,
  output logic [ADDRESS_WIDTH-1:0] uk_port,
  output logic [CNT_WIDTH-1:0]     step_idx,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     err,
  output logic [1:0]               err_code
);

  import interp_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [WORD_SIZE-1:0]     r_tk;
  logic [ADDRESS_WIDTH-1:0] r_uk;
  logic [CNT_WIDTH-1:0]     r_idx;
  logic [CNT_WIDTH-1:0]     r_n_steps;
  logic [WORD_SIZE-1:0]     r_h_step;
  logic [ADDRESS_WIDTH-1:0] r_u_stride;
  logic [TW-1:0]            r_timer;
  logic                     r_seq_done;
  logic                     r_err;
  logic [1:0]               r_err_code;

  logic [TW:0]              w_timer_inc;
  logic [CNT_WIDTH-1:0]     w_last_idx;
  logic [WORD_SIZE-1:0]     w_tk_sum;
  logic                     w_tk_ovf;
  logic                     w_accept;
  logic                     w_advance;
  logic                     w_err_set;
  logic [1:0]               w_err_code_next;
  logic                     w_init_sg;
  logic                     w_start_sg;
  logic                     w_busy;

  sat_add_detect #(
    .WIDTH (WORD_SIZE)
  ) u_tk_add (
    .i_a   (r_tk),
    .i_b   (r_h_step),
    .o_sum (w_tk_sum),
    .o_ovf (w_tk_ovf)
  );

  // The timer holds the number of WAIT cycles already spent; the timeout
  // fires on the edge where that count would reach TIMEOUT, so the error
  // becomes visible TIMEOUT+1 cycles after the start_sg pulse.
  assign w_timer_inc = {1'b0, r_timer} + (TW+1)'(1);
  assign w_last_idx  = r_n_steps - CNT_WIDTH'(1);

  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    w_advance       = 1'b0;
    w_err_set       = 1'b0;
    w_err_code_next = ERR_NONE;
    w_init_sg       = 1'b0;
    w_start_sg      = 1'b0;
    w_busy          = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          w_accept     = 1'b1;
          w_next_state = (n_steps == '0) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        w_init_sg    = 1'b1;
        w_busy       = 1'b1;
        w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        w_start_sg   = 1'b1;
        w_busy       = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        // Overflow wins over a simultaneous done.
        if (interp_overflow) begin
          w_next_state    = S_ERR;
          w_err_set       = 1'b1;
          w_err_code_next = ERR_IOVF;
        end else if (interp_done) begin
          w_next_state = S_ADVANCE;
        end else if (w_timer_inc == (TW+1)'(TIMEOUT)) begin
          w_next_state    = S_ERR;
          w_err_set       = 1'b1;
          w_err_code_next = ERR_TMO;
        end
      end
      S_ADVANCE: begin
        w_busy = 1'b1;
        // The tk add is only checked when another point follows.
        if (r_idx == w_last_idx) begin
          w_next_state = S_DONE;
        end else if (w_tk_ovf) begin
          w_next_state    = S_ERR;
          w_err_set       = 1'b1;
          w_err_code_next = ERR_TOVF;
        end else begin
          w_advance    = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tk       <= '0;
      r_uk       <= '0;
      r_idx      <= '0;
      r_n_steps  <= '0;
      r_h_step   <= '0;
      r_u_stride <= '0;
      r_timer    <= '0;
      r_seq_done <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state <= w_next_state;
      // Pulse on entry to DONE, including a zero-length run re-started from DONE.
      r_seq_done <= (w_next_state == S_DONE) && ((r_state != S_DONE) || w_accept);
      if (w_accept) begin
        r_tk       <= t_begin;
        r_uk       <= uk_base;
        r_idx      <= '0;
        r_n_steps  <= n_steps;
        r_h_step   <= h_step;
        r_u_stride <= u_stride;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= w_timer_inc[TW-1:0];
      end
      if (w_advance) begin
        r_tk  <= w_tk_sum;
        r_uk  <= r_uk + r_u_stride;
        r_idx <= r_idx + CNT_WIDTH'(1);
      end
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_next;
      end
    end
  end

  assign init_sg  = w_init_sg;
  assign start_sg = w_start_sg;
  assign busy     = w_busy;
  assign tk_port  = r_tk;
  assign uk_port  = r_uk;
  assign step_idx = r_idx;
  assign seq_done = r_seq_done;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_interp_step_sequencer.sv
// tb_interp_step_sequencer
//   Scoreboard bench: each run's expected event stream (init, starts with
//   tk/uk/idx, done or error with code, each with its cycle) is computed
//   from plain integer arithmetic and queued when go is issued; a monitor
//   pops and compares whenever the DUT shows an event.
module tb_interp_step_sequencer;

  localparam int TIMEOUT = 1023;

  localparam int EV_INIT  = 0;
  localparam int EV_START = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  localparam int K_DONE = 0;
  localparam int K_OVF  = 1;
  localparam int K_NONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int tk;
    int uk;
    int idx;
    int code;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [15:0] t_begin;
  logic [15:0] h_step;
  logic [9:0]  n_steps;
  logic [15:0] uk_base;
  logic [15:0] u_stride;
  logic        interp_done = 1'b0;
  logic        interp_overflow = 1'b0;
  logic        init_sg;
  logic        start_sg;
  logic [15:0] tk_port;
  logic [15:0] uk_port;
  logic [9:0]  step_idx;
  logic        busy;
  logic        seq_done;
  logic        err;
  logic [1:0]  err_code;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  evt_t sb[$];
  int   planKind[16];
  int   planDelay[16];
  int   expTk, expUk, expIdx, expErr, expCode;

  interp_step_sequencer #(
    .WORD_SIZE     (16),
    .ADDRESS_WIDTH (16),
    .CNT_WIDTH     (10),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .go              (go),
    .t_begin         (t_begin),
    .h_step          (h_step),
    .n_steps         (n_steps),
    .uk_base         (uk_base),
    .u_stride        (u_stride),
    .interp_done     (interp_done),
    .interp_overflow (interp_overflow),
    .init_sg         (init_sg),
    .start_sg        (start_sg),
    .tk_port         (tk_port),
    .uk_port         (uk_port),
    .step_idx        (step_idx),
    .busy            (busy),
    .seq_done        (seq_done),
    .err             (err),
    .err_code        (err_code)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void pushEv(input int k, input int c, input int tk, input int uk,
                                 input int idx, input int code);
    evt_t e;
    e.kind = k; e.cyc = c; e.tk = tk; e.uk = uk; e.idx = idx; e.code = code;
    sb.push_back(e);
  endfunction

  // Interpolator stand-in: answers each start_sg according to the plan
  // for that step, asserting its response for one cycle d cycles later.
  int pendCycle = 0;
  int pendKind  = 0;
  bit pend      = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      pend = 1'b0;
      interp_done = 1'b0;
      interp_overflow = 1'b0;
    end else begin
      interp_done = 1'b0;
      interp_overflow = 1'b0;
      if (pend && cyc == pendCycle) begin
        interp_done = 1'b1;
        if (pendKind == K_OVF) interp_overflow = 1'b1;
        pend = 1'b0;
      end
      if (start_sg === 1'b1 && planKind[step_idx[3:0]] != K_NONE) begin
        pend      = 1'b1;
        pendKind  = planKind[step_idx[3:0]];
        pendCycle = cyc + planDelay[step_idx[3:0]];
      end
    end
  end

  // Monitor: every observed event must match the head of the scoreboard.
  bit prevErr = 1'b0;
  task automatic observe(input int k, input int tk, input int uk, input int idx, input int code);
    evt_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event kind=%0d at cycle %0d, expected none", k, cyc);
    end else begin
      e = sb.pop_front();
      checkOutput("event_kind", k, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (k == EV_START && e.kind == EV_START) begin
        checkOutput("start_tk", tk, e.tk);
        checkOutput("start_uk", uk, e.uk);
        checkOutput("start_idx", idx, e.idx);
      end
      if (k == EV_ERR && e.kind == EV_ERR) checkOutput("err_code", code, e.code);
    end
  endtask

  always @(negedge clk) begin
    if (init_sg === 1'b1) observe(EV_INIT, 0, 0, 0, 0);
    if (start_sg === 1'b1)
      observe(EV_START, int'($signed(tk_port)), int'(uk_port), int'(step_idx), 0);
    if (seq_done === 1'b1) observe(EV_DONE, 0, 0, 0, 0);
    if (err === 1'b1 && !prevErr) observe(EV_ERR, 0, 0, 0, int'(err_code));
    prevErr = (err === 1'b1);
  end

  // Reference model: walks the points with integer arithmetic and the
  // response plan, queues the event stream and records final outputs.
  task automatic modelRun(input int g, input int tb, input int h, input int n,
                          input int ub, input int st, output int endC);
    int s, tk, uk, nt, d;
    bit fin;
    tk = tb; uk = ub; expErr = 0; expCode = 0; expIdx = 0; endC = g + 1;
    if (n == 0) begin
      pushEv(EV_DONE, g + 1, 0, 0, 0, 0);
    end else begin
      pushEv(EV_INIT, g + 1, 0, 0, 0, 0);
      s = g + 2;
      fin = 1'b0;
      for (int i = 0; i < n && !fin; i++) begin
        expIdx = i;
        d = planDelay[i];
        pushEv(EV_START, s, tk, uk, i, 0);
        if (planKind[i] == K_OVF) begin
          pushEv(EV_ERR, s + d + 1, 0, 0, 0, 1);
          expErr = 1; expCode = 1; endC = s + d + 1; fin = 1'b1;
        end else if (planKind[i] == K_NONE) begin
          pushEv(EV_ERR, s + TIMEOUT + 1, 0, 0, 0, 3);
          expErr = 1; expCode = 3; endC = s + TIMEOUT + 1; fin = 1'b1;
        end else if (i == n - 1) begin
          pushEv(EV_DONE, s + d + 2, 0, 0, 0, 0);
          endC = s + d + 2; fin = 1'b1;
        end else begin
          nt = tk + h;
          if (nt > 32767 || nt < -32768) begin
            pushEv(EV_ERR, s + d + 2, 0, 0, 0, 2);
            expErr = 1; expCode = 2; endC = s + d + 2; fin = 1'b1;
          end else begin
            tk = nt;
            uk = (uk + st) % 65536;
            s  = s + d + 2;
          end
        end
      end
    end
    expTk = tk;
    expUk = uk;
  endtask

  task automatic applyStimulus(input logic [15:0] tb, input logic [15:0] h, input int n,
                               input logic [15:0] ub, input logic [15:0] st, input bit midGo);
    int g, endC;
    @(negedge clk);
    t_begin = tb; h_step = h; n_steps = 10'(n); uk_base = ub; u_stride = st; go = 1'b1;
    g = cyc;
    modelRun(g, int'($signed(tb)), int'($signed(h)), n, int'(ub), int'(st), endC);
    @(negedge clk);
    go = 1'b0;
    t_begin = 16'($urandom); h_step = 16'($urandom); n_steps = 10'($urandom);
    uk_base = 16'($urandom); u_stride = 16'($urandom);
    if (midGo) begin
      while (cyc < g + 3) @(negedge clk);
      go = 1'b1;
      n_steps = 10'd0;
      @(negedge clk);
      go = 1'b0;
    end
    while (cyc < endC + 2) @(negedge clk);
    checkOutput("final_tk", {{16{tk_port[15]}}, tk_port}, expTk);
    checkOutput("final_uk", uk_port, expUk);
    checkOutput("final_idx", step_idx, expIdx);
    checkOutput("final_err", err, expErr);
    checkOutput("final_err_code", err_code, expCode);
    checkOutput("final_busy", busy, 0);
    checkOutput("pending_events", sb.size(), 0);
    sb.delete();
  endtask

  task automatic setPlan(input int kind, input int delay);
    for (int i = 0; i < 16; i++) begin
      planKind[i]  = kind;
      planDelay[i] = delay;
    end
  endtask

  initial begin
    int g, n, endC;
    logic [15:0] tb, h;
    rst = 1'b0; go = 1'b0;
    t_begin = '0; h_step = '0; n_steps = '0; uk_base = '0; u_stride = '0;
    setPlan(K_DONE, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tk", tk_port, 0);
    checkOutput("reset_uk", uk_port, 0);
    checkOutput("reset_idx", step_idx, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_err_code", err_code, 0);
    checkOutput("reset_pulses", {init_sg, start_sg, seq_done}, 0);
    rst = 1'b1;

    $display("[TB] nominal three-point run");
    setPlan(K_DONE, 4);
    applyStimulus(16'h0080, 16'h0040, 3, 16'h0200, 16'h0003, 1'b0);

    $display("[TB] zero-length run");
    applyStimulus(16'h1234, 16'h0040, 0, 16'h0055, 16'h0003, 1'b0);

    $display("[TB] tk overflow");
    applyStimulus(16'h7F80, 16'h0100, 2, 16'h0000, 16'h0001, 1'b0);

    $display("[TB] interpolator overflow with simultaneous done");
    setPlan(K_DONE, 2);
    planKind[0] = K_OVF; planDelay[0] = 3;
    applyStimulus(16'h0100, 16'h0080, 3, 16'h0010, 16'h0004, 1'b0);

    $display("[TB] done timeout then restart");
    setPlan(K_DONE, 3);
    planKind[0] = K_NONE;
    applyStimulus(16'h0000, 16'h0080, 2, 16'h0100, 16'h0001, 1'b0);
    setPlan(K_DONE, 3);
    applyStimulus(16'h0040, 16'hFFC0, 3, 16'h0100, 16'h0001, 1'b0);

    $display("[TB] go while busy, uk wrap");
    setPlan(K_DONE, 2);
    applyStimulus(16'h0200, 16'h0080, 3, 16'hFFFE, 16'h0003, 1'b1);

    $display("[TB] reset during WAIT");
    setPlan(K_NONE, 1);
    @(negedge clk);
    t_begin = 16'h0300; h_step = 16'h0080; n_steps = 10'd3;
    uk_base = 16'h0400; u_stride = 16'h0002; go = 1'b1;
    g = cyc;
    modelRun(g, 16'h0300, 16'h0080, 3, 16'h0400, 16'h0002, endC);
    @(negedge clk);
    go = 1'b0;
    while (cyc < g + 4) @(negedge clk);
    checkOutput("mid_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_tk", tk_port, 0);
    checkOutput("midrst_uk", uk_port, 0);
    checkOutput("midrst_idx", step_idx, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_err", {err, err_code}, 0);
    checkOutput("midrst_pulses", {init_sg, start_sg, seq_done}, 0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("idle_after_rst_busy", busy, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < 16; i++) begin
        planKind[i]  = ($urandom_range(0, 14) == 0) ? K_OVF : K_DONE;
        planDelay[i] = $urandom_range(1, 6);
      end
      tb = 16'($urandom);
      h  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
      applyStimulus(tb, h, n, 16'($urandom), 16'($urandom), (n > 0) && ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
